// File: rtl/movimiento_ctrl.sv
// movimiento_ctrl: motion sequencer for a two-wheel drive.
//   Accepts a motion code plus a run time in ms. If the new code would reverse
//   either wheel relative to the last code that ran, a DEAD stop phase of DEAD_MS
//   is inserted before RUN. Runs end on timeout (done pulse) or on abort.
//   If the block stays idle for DEAD_MS, it forgets the last direction, so the
//   next start needs no dead time.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cmd[2:0]          motion code (000 stop .. 101 spin, 11x invalid)
//   dur_ms[15:0]      run length in ms, 0 = run until abort
//   start, abort      one-cycle requests
//   estado[2:0]       code driven to the motor block (000 outside RUN)
//   busy              high in DEAD or RUN
//   done, err         one-cycle pulses: timed completion / rejected start
//   remaining[15:0]   whole ms left in current phase, 0 in IDLE
module movimiento_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int DEAD_MS  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cmd,
  input  logic [15:0] dur_ms,
  input  logic        start,
  input  logic        abort,
  output logic [2:0]  estado,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] remaining
);
  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]     DEAD_LEN  = 16'(DEAD_MS);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_RUN} state_t;

  state_t         r_state, w_next;
  logic [PW-1:0]  r_presc;
  logic [15:0]    r_remaining, r_dur, r_idle_ms;
  logic [2:0]     r_cmd, r_last_cmd;
  logic           r_done, r_err;

  logic           w_accept, w_reject, w_tick, w_ph_end, w_rev, w_idle_clr;
  logic [2:0]     w_estado;
  logic           w_busy;

  // Wheel drive per code as {right, left}; 01 = fwd, 10 = back, 00 = off.
  function automatic logic [3:0] wheels(input logic [2:0] c);
    case (c)
      3'b001:  wheels = 4'b01_01;
      3'b010:  wheels = 4'b10_10;
      3'b011:  wheels = 4'b01_00;
      3'b100:  wheels = 4'b00_01;
      3'b101:  wheels = 4'b10_01;
      default: wheels = 4'b00_00;
    endcase
  endfunction

  // fwd<->back is the only pair whose encodings XOR to 11.
  function automatic logic reversal(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] x;
    x = wheels(a) ^ wheels(b);
    reversal = (x[3:2] == 2'b11) || (x[1:0] == 2'b11);
  endfunction

  assign w_accept = (r_state == S_IDLE) && start && !abort && (cmd <= 3'd5);
  assign w_reject = (r_state == S_IDLE) && start && !abort && (cmd > 3'd5);
  assign w_tick   = (r_presc == TICK_LAST);
  assign w_ph_end = w_tick && (r_remaining == 16'd1);
  assign w_rev    = reversal(r_last_cmd, cmd) && (DEAD_LEN != 16'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort always wins over completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_rev ? S_DEAD : S_RUN;
      S_DEAD: if (abort) w_next = S_IDLE;
              else if (w_ph_end) w_next = S_RUN;
      S_RUN:  if (abort) w_next = S_IDLE;
              else if ((r_dur != 16'd0) && w_ph_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs from state; estado falls to 000 the instant reset clears r_state.
  always_comb begin
    w_estado = 3'b000;
    w_busy   = 1'b0;
    case (r_state)
      S_DEAD: w_busy = 1'b1;
      S_RUN:  begin w_busy = 1'b1; w_estado = r_cmd; end
      default: ;
    endcase
  end

  assign estado    = w_estado;
  assign busy      = w_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign remaining = r_remaining;

  // Idle ms counter reaches DEAD_MS on this tick -> last direction expires.
  assign w_idle_clr = (r_state == S_IDLE) && (w_next == S_IDLE) && w_tick &&
                      (r_idle_ms != DEAD_LEN) && ((r_idle_ms + 16'd1) == DEAD_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_remaining <= '0;
      r_dur       <= '0;
      r_idle_ms   <= '0;
      r_cmd       <= '0;
      r_last_cmd  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Prescaler restarts on any state change so each phase starts on a full ms.
      r_presc <= ((w_next != r_state) || w_tick) ? '0 : r_presc + 1'b1;

      if (w_next == S_IDLE)
        r_remaining <= '0;
      else if ((w_next == S_DEAD) && (r_state != S_DEAD))
        r_remaining <= DEAD_LEN;
      else if ((w_next == S_RUN) && (r_state != S_RUN))
        r_remaining <= (r_state == S_IDLE) ? dur_ms : r_dur;
      else if (w_tick && (r_remaining != 16'd0))
        r_remaining <= r_remaining - 16'd1;

      if (w_accept) begin
        r_cmd <= cmd;
        r_dur <= dur_ms;
      end

      if ((w_next == S_RUN) && (r_state != S_RUN))
        r_last_cmd <= (r_state == S_IDLE) ? cmd : r_cmd;
      else if (w_idle_clr)
        r_last_cmd <= 3'b000;

      if ((r_state == S_IDLE) && (w_next == S_IDLE)) begin
        if (w_tick && (r_idle_ms != DEAD_LEN)) r_idle_ms <= r_idle_ms + 16'd1;
      end else begin
        r_idle_ms <= '0;
      end

      r_done <= (r_state == S_RUN) && (w_next == S_IDLE) && !abort;
      r_err  <= w_reject;
    end
  end
endmodule

// File: tb/tb_movimiento_ctrl.sv
// Scoreboard bench for movimiento_ctrl with TICK_DIV=4, DEAD_MS=2
// (1 ms = 4 cycles, dead time = 8 cycles).
module tb_movimiento_ctrl;
  logic        clk, rst_n, start, abort;
  logic [2:0]  cmd, estado;
  logic [15:0] dur_ms, remaining;
  logic        busy, done, err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] est;
    logic       bz, dn, er;
    int         rem;
    string      tag;
  } exp_t;
  exp_t q[$];

  movimiento_ctrl #(.TICK_DIV(4), .DEAD_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .dur_ms(dur_ms),
    .start(start), .abort(abort), .estado(estado), .busy(busy),
    .done(done), .err(err), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge,
  // then pop and compare on the following falling edge.
  task automatic cyc(input logic s, input logic a, input logic [2:0] c, input logic [15:0] d,
                     input logic [2:0] est, input logic bz, input logic dn, input logic er,
                     input int rem, input string tag);
    exp_t e;
    start = s; abort = a; cmd = c; dur_ms = d;
    e.est = est; e.bz = bz; e.dn = dn; e.er = er; e.rem = rem; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    e = q.pop_front();
    chk({e.tag, ".estado"}, {13'd0, estado}, {13'd0, e.est});
    chk({e.tag, ".busy"},   {15'd0, busy},   {15'd0, e.bz});
    chk({e.tag, ".done"},   {15'd0, done},   {15'd0, e.dn});
    chk({e.tag, ".err"},    {15'd0, err},    {15'd0, e.er});
    chk({e.tag, ".rem"},    remaining,       16'(e.rem));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 3'b000, 16'd0, 3'b000, 0, 0, 0, 0, "idle");
  endtask

  // Timed run with no dead time: dur ms of estado=c, then done.
  task automatic run_timed(input logic [2:0] c, input int dur, input string tag);
    for (int i = 0; i < dur * 4; i++)
      cyc(i == 0, 0, c, 16'(dur), c, 1, 0, 0, dur - i / 4, tag);
    cyc(0, 0, 3'b000, 16'd0, 3'b000, 0, 1, 0, 0, {tag, "_done"});
  endtask

  // Start that must pass through 8 cycles of dead time first.
  task automatic run_dead(input logic [2:0] c, input int dur, input string tag);
    for (int i = 0; i < 8; i++)
      cyc(i == 0, 0, c, 16'(dur), 3'b000, 1, 0, 0, 2 - i / 4, {tag, "_dead"});
    for (int i = 0; i < dur * 4; i++)
      cyc(0, 0, 3'b000, 16'd0, c, 1, 0, 0, dur - i / 4, {tag, "_run"});
    cyc(0, 0, 3'b000, 16'd0, 3'b000, 0, 1, 0, 0, {tag, "_done"});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cmd = 3'b000; dur_ms = 16'd0;
    #1;
    chk("rst.estado", {13'd0, estado}, 16'd0);
    chk("rst.busy",   {15'd0, busy},   16'd0);
    chk("rst.done",   {15'd0, done},   16'd0);
    chk("rst.err",    {15'd0, err},    16'd0);
    chk("rst.rem",    remaining,       16'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Forward 3 ms, then immediate reverse needs dead time.
    run_timed(3'b001, 3, "fwd");
    run_dead(3'b010, 1, "rev");

    // Idle long enough to forget direction; timed stop; then fwd.
    idle(10);
    run_timed(3'b000, 1, "tstop");
    run_timed(3'b001, 1, "fwd2");
    idle(10);
    run_timed(3'b010, 1, "rev_nodead");

    // Untimed left turn, aborted.
    idle(10);
    cyc(1, 0, 3'b011, 16'd0, 3'b011, 1, 0, 0, 0, "left");
    for (int i = 0; i < 49; i++) cyc(0, 0, 3'b000, 16'd0, 3'b011, 1, 0, 0, 0, "left_run");
    cyc(0, 1, 3'b000, 16'd0, 3'b000, 0, 0, 0, 0, "abort");
    cyc(0, 0, 3'b000, 16'd0, 3'b000, 0, 0, 0, 0, "abort_nodone");
    // Abort kept last_cmd=011, so reverse still needs dead time.
    run_dead(3'b010, 1, "abort_keep");

    // Invalid code.
    cyc(1, 0, 3'b111, 16'd5, 3'b000, 0, 0, 1, 0, "badcmd");
    cyc(0, 0, 3'b000, 16'd0, 3'b000, 0, 0, 0, 0, "badcmd_after");

    // Start during RUN ignored.
    idle(10);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) cyc(1, 0, 3'b010, 16'd1, 3'b001, 1, 0, 0, 2 - i / 4, "busy_start");
      else        cyc(i == 0, 0, 3'b001, 16'd2, 3'b001, 1, 0, 0, 2 - i / 4, "busy_run");
    end
    cyc(0, 0, 3'b000, 16'd0, 3'b000, 0, 1, 0, 0, "busy_done");

    // Start+abort in IDLE does nothing.
    cyc(1, 1, 3'b001, 16'd2, 3'b000, 0, 0, 0, 0, "st_ab");
    idle(3);

    // Async reset mid-RUN, then no dead time afterwards.
    idle(10);
    cyc(1, 0, 3'b101, 16'd0, 3'b101, 1, 0, 0, 0, "spin");
    for (int i = 0; i < 4; i++) cyc(0, 0, 3'b000, 16'd0, 3'b101, 1, 0, 0, 0, "spin_run");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.estado", {13'd0, estado}, 16'd0);
    chk("async_rst.busy",   {15'd0, busy},   16'd0);
    chk("async_rst.rem",    remaining,       16'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_timed(3'b010, 1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/movimiento_ctrl.md
MOVIMIENTO_CTRL -- requirements
Module: movimiento_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, gives the clk cycles per 1 ms tick.
REQ-002 Parameter DEAD_MS, default 20, gives the stop time in ms inserted before a wheel reverses direction.
REQ-003 clk  input  1  rising-edge system clock (single clock domain).
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd  input  3  motion code: 000 stop, 001 forward, 010 reverse, 011 left, 100 right, 101 spin.
REQ-006 dur_ms  input  16  run duration in ms; 0 means run until abort.
REQ-007 start  input  1  one-cycle request; cmd and dur_ms are sampled on the same cycle.
REQ-008 abort  input  1  one-cycle request to terminate the current operation.
REQ-009 estado  output  3  motion code driven to the motor-drive block.
REQ-010 busy  output  1  high while in DEAD or RUN.
REQ-011 done  output  1  one-cycle pulse when a timed run completes normally.
REQ-012 err  output  1  one-cycle pulse when a start is rejected.
REQ-013 remaining  output  16  whole ms left in the current phase; 0 in IDLE.

Function
REQ-014 The FSM shall have three states: IDLE, DEAD and RUN. estado shall be 000 in IDLE and DEAD, and shall equal the latched cmd in RUN.
REQ-015 The tick prescaler shall count 0..TICK_DIV-1 and shall restart at 0 on every entry to DEAD or RUN, so that the first ms of each phase is a full ms.
REQ-016 Wheel direction per code shall be as follows.
- Right wheel: fwd for 001 and 011; back for 010 and 101; off for 000 and 100.
- Left wheel: fwd for 001, 100 and 101; back for 010; off for 000 and 011.
REQ-017 A reversal shall exist when either wheel is fwd in last_cmd and back in the new cmd, or back in last_cmd and fwd in the new cmd.
REQ-018 IDLE with start and cmd <= 101 shall latch cmd and dur_ms, and shall go to DEAD if a reversal exists, else to RUN.
- busy shall be 1 on the next cycle.
- If the next state is RUN, estado = cmd on the next cycle (1-cycle latency).
REQ-019 IDLE with start and cmd in {110, 111} shall pulse err on the next cycle and stay in IDLE with no other state change.
REQ-020 DEAD shall last exactly DEAD_MS*TICK_DIV cycles and then enter RUN.
REQ-021 RUN with dur_ms != 0 shall hold estado = cmd for exactly dur_ms*TICK_DIV cycles. On the following cycle it shall set estado = 000, pulse done, drop busy and return to IDLE.
REQ-022 RUN with dur_ms = 0 shall hold until abort, with remaining held at 0.
REQ-023 remaining shall load dur_ms (RUN) or DEAD_MS (DEAD) on phase entry and shall decrement on each tick.
REQ-024 last_cmd shall update to cmd on every RUN entry.
REQ-025 The IDLE idle-ms counter shall clear last_cmd to 000 after DEAD_MS consecutive ticks in IDLE.
REQ-026 abort in DEAD or RUN shall take effect on the next cycle: estado = 000, IDLE, busy = 0, no done pulse.
REQ-027 An abort from RUN shall keep last_cmd.
REQ-028 start while busy shall be ignored with no err.
REQ-029 start and abort on the same cycle shall act as abort: in IDLE nothing happens; when busy the abort rule applies.
REQ-030 cmd = 000 with dur_ms != 0 shall be a timed stop: RUN with estado 000, never a reversal, done at the end.

Reset
REQ-031 While rst_n = 0 the block shall hold IDLE with estado = 000, busy = 0, done = 0, err = 0, remaining = 0, last_cmd = 000, and prescaler and counters at 0.
REQ-032 Reset mid-RUN or mid-DEAD shall force estado = 000 immediately, without waiting for a clk edge.
REQ-033 Operation shall resume on the first clk edge after rst_n rises.

Verification (bench: TICK_DIV=4, DEAD_MS=2)
REQ-034 start cmd=001 dur=3 -> estado=001 from cycle+1 for 12 cycles, then estado=000 with a single done pulse and busy=0.
REQ-035 After REQ-034, start at once with cmd=010 dur=1 -> 8 cycles of estado=000 with busy=1, then estado=010 for 4 cycles, then done.
REQ-036 001 run, then 10 idle cycles, then start cmd=010 -> no dead time; estado=010 at cycle+1.
REQ-037 start cmd=011 dur=0, then abort after 50 cycles -> estado=000 on the next cycle, no done, busy=0.
REQ-038 start cmd=111 -> err pulse, busy stays 0; start during RUN -> ignored; start+abort in IDLE -> no activity.
REQ-039 Assert rst_n=0 mid-RUN with cmd=101 -> estado=000 asynchronously; after release, start cmd=010 -> no dead time.
